// File: rtl/nco_freq_meter.sv
// nco_freq_meter: recovers the phase increment of a periodic 7-bit waveform
// by timing NCYC mid-scale crossings and dividing (NCYC << W) by the count.
module nco_freq_meter #(
  parameter int W    = 10,
  parameter int DW   = 8,
  parameter int NCYC = 4,
  parameter int CW   = 20,
  parameter int HYST = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [6:0]    i_val,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_timeout,
  output logic [DW-1:0] o_dphase
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DIV   = 2'd3;

  localparam int KW  = $clog2(NCYC + 1);
  localparam int DCW = $clog2(CW + 1);

  localparam logic [CW-1:0]  NUM   = CW'(NCYC << W);
  localparam logic [CW-1:0]  NLIM  = CW'((64'd1 << CW) - 64'd2);
  localparam logic [CW-1:0]  QSAT  = CW'((64'd1 << DW) - 64'd1);
  localparam logic [KW-1:0]  KLAST = KW'(NCYC - 1);
  localparam logic [DCW-1:0] DLAST = DCW'(CW - 1);
  localparam logic [6:0]     MID   = 7'd64;
  localparam logic [6:0]     LOTH  = 7'(64 - HYST);

  logic [1:0]     state_q, state_d;
  logic           low_q, low_d;
  logic [CW-1:0]  n_q, n_d;
  logic [KW-1:0]  k_q, k_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [CW-1:0]  quo_q, quo_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [DW-1:0]  dphase_q, dphase_d;
  logic           valid_q, valid_d;
  logic           tout_q, tout_d;

  logic           xing;
  logic           n_hit;
  logic           k_done;
  logic [CW-1:0]  n_inc;
  logic [CW:0]    rem_sh;
  logic [CW-1:0]  diff;
  logic           ge;
  logic [CW-1:0]  rem_nx;
  logic [CW-1:0]  quo_nx;

  assign xing   = i_ce & low_q & (i_val >= MID);
  assign n_hit  = i_ce & (n_q == NLIM);
  assign k_done = xing & (k_q == KLAST);
  assign n_inc  = n_q + CW'(1);

  // One restoring-division step: shift in the next dividend bit, try subtract.
  always_comb begin
    rem_sh = {rem_q, quo_q[CW-1]};
    diff   = rem_sh[CW-1:0] - n_q;
    ge     = (rem_sh >= {1'b0, n_q});
    rem_nx = ge ? diff : rem_sh[CW-1:0];
    quo_nx = {quo_q[CW-2:0], ge};
  end

  // Crossing detector: arm below mid-scale minus hysteresis, fire at mid-scale.
  always_comb begin
    low_d = low_q;
    if (i_ce) begin
      if (xing) begin
        low_d = 1'b0;
      end else if (i_val <= LOTH) begin
        low_d = 1'b1;
      end
    end
  end

  // Measurement sequencer: sync, count samples over NCYC cycles, divide.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dcnt_d   = dcnt_q;
    dphase_d = dphase_q;
    valid_d  = 1'b0;
    tout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SYNC;
          n_d     = '0;
          k_d     = '0;
        end
      end
      S_SYNC: begin
        if (xing) begin
          state_d = S_COUNT;
          n_d     = '0;
          k_d     = '0;
        end else if (n_hit) begin
          state_d  = S_IDLE;
          tout_d   = 1'b1;
          dphase_d = '0;
        end else if (i_ce) begin
          n_d = n_inc;
        end
      end
      S_COUNT: begin
        if (i_ce) begin
          n_d = n_inc;
          if (xing) begin
            k_d = k_q + KW'(1);
          end
          if (k_done) begin
            state_d = S_DIV;
            rem_d   = '0;
            quo_d   = NUM;
            dcnt_d  = '0;
          end else if (n_hit) begin
            state_d  = S_IDLE;
            tout_d   = 1'b1;
            dphase_d = '0;
          end
        end
      end
      default: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        dcnt_d = dcnt_q + DCW'(1);
        if (dcnt_q == DLAST) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          dphase_d = (quo_nx > QSAT) ? '1 : quo_nx[DW-1:0];
        end
      end
    endcase
  end

  // State registers; reset wins over everything, including DIV completion.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      low_q    <= 1'b0;
      n_q      <= '0;
      k_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dcnt_q   <= '0;
      dphase_q <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      low_q    <= low_d;
      n_q      <= n_d;
      k_q      <= k_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dcnt_q   <= dcnt_d;
      dphase_q <= dphase_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_valid   = valid_q;
  assign o_timeout = tout_q;
  assign o_dphase  = dphase_q;

endmodule

// File: tb/tb_nco_freq_meter.sv
// tb_nco_freq_meter: randomized bench for nco_freq_meter with a
// sample-stream reference model (crossing list -> expected dphase/timing).
module tb_nco_freq_meter;

  localparam int W    = 10;
  localparam int DW   = 8;
  localparam int NCYC = 4;
  localparam int CW   = 14;
  localparam int HYST = 8;
  localparam int NMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_ce = 1'b0;
  logic [6:0]    i_val = '0;
  logic          i_start = 1'b0;
  logic          o_busy;
  logic          o_valid;
  logic          o_timeout;
  logic [DW-1:0] o_dphase;

  nco_freq_meter #(
    .W(W), .DW(DW), .NCYC(NCYC), .CW(CW), .HYST(HYST)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_val(i_val),
    .i_start(i_start), .o_busy(o_busy), .o_valid(o_valid),
    .o_timeout(o_timeout), .o_dphase(o_dphase)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rst = 1'b0;
  bit m_low = 1'b0;
  bit last_ev = 1'b0;
  int gmode = 0;
  logic [W-1:0] phase = '0;
  logic [W-1:0] dph = '0;
  bit galt = 1'b0;
  bit ace = 1'b0;

  function automatic bit pick_ce(input int m);
    if (m == 0) return 1'b1;
    if (m == 1) begin ace = ~ace; return ace; end
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick(input bit ce, input bit st);
    logic [6:0] v;
    v = 7'($urandom);
    if (ce) begin
      if (gmode == 0) begin
        v = phase[W-1:W-7];
        phase = phase + dph;
      end else if (gmode == 1) begin
        v = galt ? 7'd127 : 7'd0;
        galt = ~galt;
      end else begin
        v = 7'd64;
      end
    end
    i_ce = ce; i_val = v; i_start = st; i_reset = rst;
    @(posedge clk);
    cyc++;
    last_ev = 1'b0;
    if (rst) m_low = 1'b0;
    else if (ce) begin
      if (m_low && v >= 7'd64) begin last_ev = 1'b1; m_low = 1'b0; end
      else if (v <= 7'(64 - HYST)) m_low = 1'b1;
    end
    #1;
  endtask

  task automatic do_measure(
    input int cem, input bit extra, input int budget, input int tail,
    output int vcyc, output int ecyc, output int gdp, output int edp,
    output int nv, output int nt, output int tcyc, output int etcyc,
    output bit bstart, output bit bend);
    bit evq[$];
    int cq[$];
    int j0, seen;
    bit ce;
    nv = 0; nt = 0; vcyc = -1; tcyc = -1; gdp = -1; bend = 1'b1;
    tick(pick_ce(cem), 1'b1);
    bstart = o_busy;
    for (int t = 0; t < budget; t++) begin
      ce = pick_ce(cem);
      tick(ce, extra && ($urandom_range(0, 7) == 0));
      if (ce) begin evq.push_back(last_ev); cq.push_back(cyc); end
      if (o_valid) nv++;
      if (o_timeout) nt++;
      if (o_valid || o_timeout) begin
        vcyc = o_valid ? cyc : -1;
        tcyc = o_timeout ? cyc : -1;
        gdp = int'(o_dphase); bend = o_busy;
        break;
      end
    end
    for (int t = 0; t < tail; t++) begin
      tick(pick_ce(cem), 1'b0);
      if (o_valid) nv++;
      if (o_timeout) nt++;
    end
    ecyc = -1; edp = -1; etcyc = -1; j0 = -1; seen = 0;
    foreach (evq[i]) begin
      if (evq[i] && j0 < 0) j0 = i;
      else if (evq[i] && ecyc < 0) begin
        seen++;
        if (seen == NCYC) begin
          ecyc = cq[i] + CW;
          edp = (NCYC << W) / (i - j0);
          if (edp > (1 << DW) - 1) edp = (1 << DW) - 1;
        end
      end
    end
    if (j0 < 0 && cq.size() >= NMAX) etcyc = cq[NMAX-1];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", o_busy); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
    tests++; if (o_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", o_timeout); end
    tests++; if (o_dphase !== '0) begin fails++; $display("FAIL reset_dphase got %0d want 0", o_dphase); end
    rst = 1'b0;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_nco(input string nm, input int d, input int cem, input int budget);
    int vc, ec, gd, ed, nv, nt, tc, etc;
    bit bs, be;
    gmode = 0; dph = W'(d);
    do_measure(cem, 1'b0, budget, 5, vc, ec, gd, ed, nv, nt, tc, etc, bs, be);
    tests++; if (gd != ed || ed < 0) begin fails++; $display("FAIL %s_dphase got %0d want %0d", nm, gd, ed); end
    tests++; if (vc != ec) begin fails++; $display("FAIL %s_vcycle got %0d want %0d", nm, vc, ec); end
    tests++; if (nv != 1 || nt != 0) begin fails++; $display("FAIL %s_pulses got v%0d t%0d want v1 t0", nm, nv, nt); end
    tests++; if (bs !== 1'b1 || be !== 1'b0) begin fails++; $display("FAIL %s_busy got s%b e%b want s1 e0", nm, bs, be); end
  endtask

  task automatic test_dphase1();
    phase = '0;
    test_nco("dph1", 1, 0, 8000);
  endtask

  task automatic test_dphase64();
    phase = W'($urandom);
    test_nco("dph64", 64, 0, 2000);
    test_nco("dph64_half", 64, 1, 4000);
  endtask

  task automatic test_saturation();
    int vc, ec, gd, ed, nv, nt, tc, etc;
    bit bs, be;
    gmode = 1;
    do_measure(0, 1'b0, 200, 5, vc, ec, gd, ed, nv, nt, tc, etc, bs, be);
    tests++; if (gd != 255 || ed != 255) begin fails++; $display("FAIL sat_dphase got %0d want 255 (model %0d)", gd, ed); end
    tests++; if (vc != ec || nv != 1) begin fails++; $display("FAIL sat_valid got c%0d n%0d want c%0d n1", vc, nv, ec); end
  endtask

  task automatic test_timeout();
    int vc, ec, gd, ed, nv, nt, tc, etc;
    bit bs, be;
    gmode = 2;
    for (int t = 0; t < 4; t++) tick(1'b1, 1'b0);
    tests++; if (o_dphase === '0) begin fails++; $display("FAIL tout_pre got %0d want nonzero", o_dphase); end
    do_measure(0, 1'b0, NMAX + 50, 20, vc, ec, gd, ed, nv, nt, tc, etc, bs, be);
    tests++; if (nt != 1 || nv != 0) begin fails++; $display("FAIL tout_pulses got t%0d v%0d want t1 v0", nt, nv); end
    tests++; if (tc != etc || etc < 0) begin fails++; $display("FAIL tout_cycle got %0d want %0d", tc, etc); end
    tests++; if (gd != 0 || be !== 1'b0) begin fails++; $display("FAIL tout_state got dp%0d busy%b want dp0 busy0", gd, be); end
  endtask

  task automatic test_reset_mid();
    int nv, nt;
    gmode = 0; dph = W'(64);
    test_nco("rm_pre", 64, 0, 2000);
    tick(1'b1, 1'b1);
    for (int t = 0; t < 40; t++) tick(1'b1, 1'b0);
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL rm_busy_before got %b want 1", o_busy); end
    rst = 1'b1;
    tick(1'b1, 1'b1);
    rst = 1'b0;
    tests++; if (o_busy !== 1'b0 || o_dphase !== '0) begin fails++; $display("FAIL rm_abort got busy%b dp%0d want busy0 dp0", o_busy, o_dphase); end
    nv = 0; nt = 0;
    for (int t = 0; t < 80; t++) begin
      tick(1'b1, 1'b0);
      if (o_valid) nv++;
      if (o_timeout) nt++;
    end
    tests++; if (nv != 0 || nt != 0 || o_busy !== 1'b0) begin fails++; $display("FAIL rm_quiet got v%0d t%0d busy%b want 0 0 0", nv, nt, o_busy); end
    test_nco("rm_post", 64, 0, 2000);
  endtask

  task automatic test_start_while_busy();
    int vc, ec, gd, ed, nv, nt, tc, etc;
    bit bs, be;
    gmode = 0; dph = W'(64);
    do_measure(0, 1'b1, 2000, 40, vc, ec, gd, ed, nv, nt, tc, etc, bs, be);
    tests++; if (nv != 1 || nt != 0) begin fails++; $display("FAIL swb_pulses got v%0d t%0d want v1 t0", nv, nt); end
    tests++; if (gd != ed || vc != ec) begin fails++; $display("FAIL swb_result got %0d@%0d want %0d@%0d", gd, vc, ed, ec); end
  endtask

  task automatic test_back_to_back();
    int vc, ec, gd, ed, nv, nt, tc, etc;
    bit bs, be;
    gmode = 0; dph = W'(64);
    do_measure(0, 1'b0, 2000, 0, vc, ec, gd, ed, nv, nt, tc, etc, bs, be);
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid_now got %b want 1", o_valid); end
    dph = W'(100);
    do_measure(2, 1'b0, 4000, 5, vc, ec, gd, ed, nv, nt, tc, etc, bs, be);
    tests++; if (bs !== 1'b1) begin fails++; $display("FAIL b2b_accept got busy%b want 1", bs); end
    tests++; if (gd != ed || vc != ec || nv != 1) begin fails++; $display("FAIL b2b_result got %0d@%0d n%0d want %0d@%0d n1", gd, vc, nv, ed, ec); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      phase = W'($urandom);
      test_nco("rand", int'($urandom_range(5, 200)), 2, 6000);
    end
  endtask

  initial begin
    test_reset();
    test_dphase1();
    test_dphase64();
    test_saturation();
    test_timeout();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
